// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial adder/subtractor. One full-adder cell and one carry flip-flop
// process two WIDTH-bit operands LSB first, one bit per clock. Subtraction is
// a + ~b + 1: the operand B is inverted at load time and the carry flip-flop
// is preset to 1.
//
// Handshake: a start pulse in IDLE loads the operands. busy is high for the
// WIDTH cycles of RUN. done pulses for one cycle in DONE, when sum/carry hold
// the new result. sum/carry stay stable until the next completed operation.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active low
//   start  in   request, sampled only in IDLE
//   sub    in   0 = a+b, 1 = a-b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   busy   out  high during RUN
//   done   out  one-cycle result-valid pulse
//   sum    out  WIDTH-bit result (modulo 2^WIDTH)
//   carry  out  carry out of the MSB; for sub, 1 = no borrow (a >= b)
//   ovf    out  signed overflow, present only with SERIAL_ADD_SUB_OVF_EN
//
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN adds the ovf port and its
// register. Without it no overflow state is built.
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter only has to reach WIDTH-1; it is reset to 0 on the final RUN
    // cycle instead of incrementing past its range.
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shift_a_q,  shift_a_d;
    logic [WIDTH-1:0]   shift_b_q,  shift_b_d;
    logic               carry_ff_q, carry_ff_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    // Assembly register holds WIDTH-1 bits; the final bit goes straight from
    // the adder into sum on the last RUN cycle.
    logic [WIDTH-2:0]   res_q,      res_d;
    logic [WIDTH-1:0]   sum_q,      sum_d;
    logic               carry_q,    carry_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic               ovf_q,      ovf_d;
`endif

    // Full-adder cell.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shift;

    assign fa_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_ff_q;
    assign fa_c = (shift_a_q[0] & shift_b_q[0]) |
                  (shift_b_q[0] & carry_ff_q)   |
                  (shift_a_q[0] & carry_ff_q);

    // New bit enters at the MSB side; the whole word shifts right.
    assign res_shift = {fa_s, res_q};

    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_a_d  = shift_a_q;
        shift_b_d  = shift_b_q;
        carry_ff_d = carry_ff_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ovf_d      = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_a_d  = a;
                    shift_b_d  = sub ? ~b : b;
                    carry_ff_d = sub;          // +1 of the two's complement
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                shift_a_d  = shift_a_q >> 1;
                shift_b_d  = shift_b_q >> 1;
                carry_ff_d = fa_c;
                res_d      = res_shift[WIDTH-1:1];
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    sum_d   = res_shift;
                    carry_d = fa_c;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    // Carry into the MSB is the carry FF in this last cycle.
                    ovf_d   = carry_ff_q ^ fa_c;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_a_q  <= '0;
            shift_b_q  <= '0;
            carry_ff_q <= 1'b0;
            cnt_q      <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_a_q  <= shift_a_d;
            shift_b_q  <= shift_b_d;
            carry_ff_q <= carry_ff_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//
// Self-checking bench for serial_add_sub at WIDTH=8. Expected results come
// from plain integer arithmetic (unsigned sum/compare for sum and carry,
// signed range test for overflow). Inputs are driven and outputs sampled on
// the falling clock edge. Honours SERIAL_ADD_SUB_OVF_EN for the ovf port.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] last_sum   = '0;
    logic         last_carry = 1'b0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, carry, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub);
        int ua, ub, sa, sb, r;
        logic [W-1:0] s;
        logic c, o;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        s  = W'(msub ? ua - ub : ua + ub);
        c  = msub ? (ua >= ub) : (ua + ub >= (1 << W));
        r  = msub ? sa - sb : sa + sb;
        o  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {o, c, s};
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                                input logic tsub);
        logic [W+1:0] exp;
        exp = model(ta, tb2, tsub);
        check({tag, "_sum"},   64'(sum),   64'(exp[W-1:0]));
        check({tag, "_carry"}, 64'(carry), 64'(exp[W]));
`ifdef SERIAL_ADD_SUB_OVF_EN
        check({tag, "_ovf"},   64'(ovf),   64'(exp[W+1]));
`endif
        last_sum   = exp[W-1:0];
        last_carry = exp[W];
    endtask

    // One complete operation; glitch > 0 pulses a conflicting start on that
    // RUN cycle, which must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tsub,
                          input int glitch, input string tag);
        int lat;
        int busy_cnt;
        int extra_done;
        @(negedge clk);
        a = ta; b = tb2; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        check({tag, "_hold_sum"},   64'(sum),   64'(last_sum));
        check({tag, "_hold_carry"}, 64'(carry), 64'(last_carry));
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == glitch) begin
                a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"},   64'(lat),      64'(W + 1));
        check({tag, "_busy_cyc"},  64'(busy_cnt), 64'(W));
        check({tag, "_busy_done"}, 64'(busy),     64'(0));
        check_result(tag, ta, tb2, tsub);
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) extra_done++;
        end
        check({tag, "_one_done"}, 64'(extra_done), 64'(0));
    endtask

    logic [W-1:0] op_a   [30];
    logic [W-1:0] op_b   [30];
    logic         op_sub [30];

    initial begin
        int nodone;
        bit exp_done;

        // Reset state.
        #1;
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_done",  64'(done),  64'(0));
        check("rst_sum",   64'(sum),   64'(0));
        check("rst_carry", 64'(carry), 64'(0));
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("rst_ovf",   64'(ovf),   64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic and boundary cases.
        run_op(8'h3C, 8'h0F, 1'b0, 0, "add_3c_0f");
        run_op(8'hFF, 8'h01, 1'b0, 0, "add_wrap");
        run_op(8'h7F, 8'h01, 1'b0, 0, "add_sovf");
        run_op(8'h05, 8'h07, 1'b1, 0, "sub_borrow");
        run_op(8'h00, 8'h00, 1'b1, 0, "sub_zero");
        run_op(8'hFF, 8'hFF, 1'b0, 0, "add_ff_ff");
        run_op(8'h80, 8'h01, 1'b1, 0, "sub_sovf");

        // start during RUN is ignored.
        run_op(8'h10, 8'h20, 1'b0, 3, "ign_start");

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  64'(busy),  64'(0));
        check("midrst_done",  64'(done),  64'(0));
        check("midrst_sum",   64'(sum),   64'(0));
        check("midrst_carry", 64'(carry), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nodone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0) nodone++;
        end
        check("midrst_no_done", 64'(nodone), 64'(0));
        last_sum = '0;
        last_carry = 1'b0;
        run_op(8'h3C, 8'h0F, 1'b0, 0, "after_rst");

        // Back-to-back: start held for 30 cycles with fresh operands each
        // cycle; accepts at edges 0, 10, 20 give done after edges 8, 18, 28.
        for (int i = 0; i < 30; i++) begin
            op_a[i]   = W'($urandom);
            op_b[i]   = W'($urandom);
            op_sub[i] = 1'($urandom);
            a = op_a[i]; b = op_b[i]; sub = op_sub[i]; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            exp_done = (i >= W) && ((i - W) % (W + 2) == 0);
            check($sformatf("b2b_done_%0d", i), 64'(done), 64'(exp_done));
            if (exp_done)
                check_result($sformatf("b2b_%0d", i), op_a[i-W], op_b[i-W], op_sub[i-W]);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random operations.
        for (int i = 0; i < 12; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, $sformatf("rnd_%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial, parametrised adder/subtractor. Next-generation replacement for the single-bit combinational full adder in the arithmetic library.
- One full-adder cell plus a carry flip-flop processes WIDTH-bit operands LSB first, one bit per clock.
- Start/busy/done handshake. Used where area matters more than latency, e.g. accumulators and checksum units.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode, sampled with start; 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while operation is in progress (RUN).
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  result; held stable from done until next accepted start.
- carry  output  1  final carry-out; for sub, 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, sum=0, carry=0, internal shift registers, carry FF and bit counter cleared. Takes effect immediately, mid-operation included. Any partial result is discarded and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Load shift_a=a.
  - Load shift_b = b if sub=0, else ~b.
  - Load carry FF = sub (two's-complement +1).
  - Counter = 0; go to RUN.
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each edge:
  - s = a0^b0^c and cout = a0&b0 | b0&c | a0&c, where a0/b0 are the LSBs of shift_a/shift_b and c is the carry FF.
  - Shift s into the result register MSB-side (result shifts right).
  - Shift shift_a and shift_b right; carry FF = cout; counter += 1.
  - On the edge where the counter reaches WIDTH-1, go to DONE.
- RUN occupies edges k+1..k+WIDTH.
- DONE (one cycle after edge k+WIDTH):
  - done=1, busy=0.
  - sum = assembled result; carry = last cout.
  - Next edge: return to IDLE unconditionally.
- busy = 1 exactly in RUN (WIDTH cycles). done = 1 exactly in DONE (1 cycle).
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles.
- start during RUN or DONE is ignored. Operands and mode are not re-sampled; no queuing.
- sum and carry update only on entry to DONE. During RUN they keep the previous result; the assembly register is internal.
- Arithmetic is modulo 2^WIDTH. The carry output is the WIDTH-th bit of the result: a + b for add, a + ~b + 1 for sub.
- Boundary: a=b=0 with sub=1 gives sum=0, carry=1. All-ones + 1 wraps to 0 with carry=1.
- Counter is sized for WIDTH-1 with no wrap hazard; it is cleared on every accepted start.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated on entry to DONE alongside sum.
  - ovf = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB, captured during the final RUN cycle.
- Not defined: port ovf is absent and no extra state is built. All other behaviour is identical.

Test Plan:
- WIDTH=8; reset then start a=8'h3C b=8'h0F sub=0 -> busy high 8 cycles; done 1 cycle later; sum=8'h4B, carry=0.
- a=8'hFF b=8'h01 sub=0 -> sum=8'h00, carry=1 (ovf=0 if enabled). Then a=8'h7F b=8'h01 sub=0 -> sum=8'h80, carry=0, ovf=1.
- a=8'h05 b=8'h07 sub=1 -> sum=8'hFE, carry=0 (borrow). Then a=8'h00 b=8'h00 sub=1 -> sum=8'h00, carry=1.
- Start a=8'h10 b=8'h20 sub=0; pulse start with a=8'hAA b=8'h55 sub=1 on the 3rd RUN cycle -> ignored; sum=8'h30, done only once, at latency 9.
- Start a=8'h3C b=8'h0F; drop rst_n on the 4th RUN cycle -> busy, done, sum, carry go 0 immediately; no done afterwards. A new start after release gives a correct result.
- Back-to-back: assert start continuously for 30 cycles -> done pulses exactly every 10 cycles (WIDTH+2), each with the sum of the operands present at the accepting edge.
